// File: rtl/connect4_defs.sv
// Shared Connect-4 constants, status codes and judge state encodings.
// Imported by move_judge, c4_line_counter and the game-control FSM.
package connect4_defs;

  localparam int C4_ROWS    = 6;
  localparam int C4_COLS    = 7;
  localparam int C4_WIN_LEN = 4;

  typedef enum logic [1:0] {
    NEXT_TURN = 2'b00,
    P1_WIN    = 2'b01,
    P2_WIN    = 2'b10,
    TIE_GAME  = 2'b11
  } status_e;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PLACE  = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_REPORT = 3'd3;
  localparam logic [2:0] S_OVER   = 3'd4;

  function automatic int cell_idx(
    input int r,
    input int c,
    input int cols
  );
    return r * cols + c;
  endfunction

endpackage

// File: rtl/c4_line_counter.sv
// Combinational line measure through one placed cell along one direction.
// Optional win_mask support is built only when C4_WIN_MASK_EN is defined.
module c4_line_counter
  import connect4_defs::*;
#(
  parameter int ROWS    = C4_ROWS,
  parameter int COLS    = C4_COLS,
  parameter int WIN_LEN = C4_WIN_LEN,
  localparam int N      = ROWS * COLS,
  localparam int RW     = $clog2(ROWS + 1)
) (
  input  logic [N-1:0]  board,
  input  logic [RW-1:0] row,
  input  logic [2:0]    col,
  input  logic [1:0]    dir,
  output logic [2:0]    len
`ifdef C4_WIN_MASK_EN
  ,
  output logic [N-1:0]  mask
`endif
);

  localparam int SPAN = (ROWS > COLS) ? ROWS : COLS;
  localparam int IW   = $clog2(N);

  int dr;
  int dc;
  int pos;
  int neg;

  function automatic logic cell_on(
    input logic [N-1:0] b,
    input int r,
    input int c
  );
    int idx;
    logic [IW-1:0] i;
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS)
      return 1'b0;
    idx = cell_idx(r, c, COLS);
    i = idx[IW-1:0];
    return b[i];
  endfunction

  // Step vector: horizontal, vertical, rising diag, falling diag
  always_comb begin
    dr = 0;
    dc = 1;
    unique case (dir)
      2'd0: begin dr = 0;  dc = 1; end
      2'd1: begin dr = 1;  dc = 0; end
      2'd2: begin dr = 1;  dc = 1; end
      default: begin dr = -1; dc = 1; end
    endcase
  end

  // Walk outward both ways until the colour breaks or the edge is hit
  always_comb begin
    logic ap;
    logic an;
    pos = 0;
    neg = 0;
    ap = 1'b1;
    an = 1'b1;
    for (int k = 1; k < SPAN; k++) begin
      if (ap && cell_on(board, int'(row) + k * dr,
                        int'(col) + k * dc))
        pos = pos + 1;
      else
        ap = 1'b0;
      if (an && cell_on(board, int'(row) - k * dr,
                        int'(col) - k * dc))
        neg = neg + 1;
      else
        an = 1'b0;
    end
  end

  assign len = 3'(1 + pos + neg);

`ifdef C4_WIN_MASK_EN
  function automatic logic [N-1:0] cell_bit(
    input int r,
    input int c
  );
    logic [N-1:0] v;
    int idx;
    logic [IW-1:0] i;
    idx = cell_idx(r, c, COLS);
    i = idx[IW-1:0];
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Keep the WIN_LEN cells nearest the placed one, forward side first
  always_comb begin
    int n;
    n = 1;
    mask = cell_bit(int'(row), int'(col));
    for (int k = 1; k < SPAN; k++) begin
      if (k <= pos && n < WIN_LEN) begin
        mask = mask | cell_bit(int'(row) + k * dr,
                               int'(col) + k * dc);
        n = n + 1;
      end
      if (k <= neg && n < WIN_LEN) begin
        mask = mask | cell_bit(int'(row) - k * dr,
                               int'(col) - k * dc);
        n = n + 1;
      end
    end
  end
`endif

endmodule

// File: rtl/move_judge.sv
// Connect-4 move judge: owns the board, places drops, detects wins/ties.
// Define C4_WIN_MASK_EN to add the win_mask output.
module move_judge
  import connect4_defs::*;
#(
  parameter int ROWS    = C4_ROWS,
  parameter int COLS    = C4_COLS,
  parameter int WIN_LEN = C4_WIN_LEN
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 new_game,
  input  logic                 drop_valid,
  input  logic [2:0]           drop_col,
  output logic                 drop_ready,
  output logic                 move_reject,
  output logic                 status_valid,
  output logic [1:0]           game_status,
  output logic                 player_turn,
  output logic [ROWS*COLS-1:0] board_p1,
  output logic [ROWS*COLS-1:0] board_p2
`ifdef C4_WIN_MASK_EN
  ,
  output logic [ROWS*COLS-1:0] win_mask
`endif
);

  localparam int N  = ROWS * COLS;
  localparam int HW = $clog2(ROWS + 1);
  localparam int MW = $clog2(N + 1);

  logic [2:0]    state;
  logic [2:0]    col;
  logic [HW-1:0] row;
  logic [HW-1:0] heights [COLS];
  logic [MW-1:0] move_cnt;
  logic [1:0]    dir;
  logic          win;
  logic [2:0]    len;
  logic          hit;
  logic          bad;
  logic          full;
  logic [N-1:0]  mover;
  logic [N-1:0]  place_bit;
`ifdef C4_WIN_MASK_EN
  logic [N-1:0]  line_mask;
  logic [N-1:0]  first_mask;
`endif

  assign drop_ready = (state == S_IDLE);
  assign bad  = int'(drop_col) >= COLS;
  assign full = !bad && (heights[drop_col] == HW'(ROWS));
  assign mover = player_turn ? board_p2 : board_p1;
  assign hit = int'(len) >= WIN_LEN;
  assign place_bit =
    N'(1) << cell_idx(int'(heights[col]), int'(col), COLS);

  c4_line_counter #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .WIN_LEN (WIN_LEN)
  ) u_line (
    .board (mover),
    .row   (row),
    .col   (col),
    .dir   (dir),
    .len   (len)
`ifdef C4_WIN_MASK_EN
    ,
    .mask  (line_mask)
`endif
  );

  // Judge sequencer: accept, place, four direction checks, report
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      col          <= '0;
      row          <= '0;
      move_cnt     <= '0;
      dir          <= '0;
      win          <= 1'b0;
      move_reject  <= 1'b0;
      status_valid <= 1'b0;
      game_status  <= NEXT_TURN;
      player_turn  <= 1'b0;
      board_p1     <= '0;
      board_p2     <= '0;
      for (int i = 0; i < COLS; i++)
        heights[i] <= '0;
`ifdef C4_WIN_MASK_EN
      first_mask   <= '0;
      win_mask     <= '0;
`endif
    end else if (new_game) begin
      state        <= S_IDLE;
      col          <= '0;
      row          <= '0;
      move_cnt     <= '0;
      dir          <= '0;
      win          <= 1'b0;
      move_reject  <= 1'b0;
      status_valid <= 1'b0;
      game_status  <= NEXT_TURN;
      player_turn  <= 1'b0;
      board_p1     <= '0;
      board_p2     <= '0;
      for (int i = 0; i < COLS; i++)
        heights[i] <= '0;
`ifdef C4_WIN_MASK_EN
      first_mask   <= '0;
      win_mask     <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (drop_valid) begin
            col         <= drop_col;
            move_reject <= bad | full;
            state       <= S_PLACE;
          end
        end
        S_PLACE: begin
          move_reject <= 1'b0;
          if (move_reject) begin
            state <= S_IDLE;
          end else begin
            if (player_turn)
              board_p2 <= board_p2 | place_bit;
            else
              board_p1 <= board_p1 | place_bit;
            row          <= heights[col];
            heights[col] <= heights[col] + HW'(1);
            move_cnt     <= move_cnt + MW'(1);
            dir          <= '0;
            win          <= 1'b0;
            state        <= S_CHECK;
          end
        end
        S_CHECK: begin
          dir <= dir + 2'd1;
          if (hit)
            win <= 1'b1;
`ifdef C4_WIN_MASK_EN
          if (hit && !win)
            first_mask <= line_mask;
`endif
          if (dir == 2'd3) begin
            state        <= S_REPORT;
            status_valid <= 1'b1;
            if (win || hit) begin
              game_status <= player_turn ? P2_WIN : P1_WIN;
`ifdef C4_WIN_MASK_EN
              win_mask <= win ? first_mask : line_mask;
`endif
            end else if (move_cnt == MW'(N)) begin
              game_status <= TIE_GAME;
            end else begin
              game_status <= NEXT_TURN;
              player_turn <= ~player_turn;
            end
          end
        end
        S_REPORT: begin
          status_valid <= 1'b0;
          if (game_status == NEXT_TURN)
            state <= S_IDLE;
          else
            state <= S_OVER;
        end
        S_OVER: begin
          state <= S_OVER;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_judge.sv
// Self-checking bench for move_judge: directed games plus random play
// scored against a cell-array reference model of the game rules.
module tb_move_judge;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;
  localparam int N       = ROWS * COLS;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         new_game = 1'b0;
  logic         drop_valid = 1'b0;
  logic [2:0]   drop_col = '0;
  logic         drop_ready;
  logic         move_reject;
  logic         status_valid;
  logic [1:0]   game_status;
  logic         player_turn;
  logic [N-1:0] board_p1;
  logic [N-1:0] board_p2;
`ifdef C4_WIN_MASK_EN
  logic [N-1:0] win_mask;
`endif

  int n_assert = 0;
  int n_fail = 0;

  int   m_cell [ROWS][COLS];
  int   m_h [COLS];
  int   m_cnt;
  int   m_turn;
  logic [1:0] m_status;
  bit   m_over;

  always #5 clk = ~clk;

  move_judge dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .new_game     (new_game),
    .drop_valid   (drop_valid),
    .drop_col     (drop_col),
    .drop_ready   (drop_ready),
    .move_reject  (move_reject),
    .status_valid (status_valid),
    .game_status  (game_status),
    .player_turn  (player_turn),
    .board_p1     (board_p1),
    .board_p2     (board_p2)
`ifdef C4_WIN_MASK_EN
    ,
    .win_mask     (win_mask)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_cell[r][c] = 0;
    for (int c = 0; c < COLS; c++)
      m_h[c] = 0;
    m_cnt = 0;
    m_turn = 0;
    m_status = 2'b00;
    m_over = 1'b0;
  endfunction

  function automatic int m_run(int r, int c, int dr, int dc, int p);
    int n = 0;
    r = r + dr;
    c = c + dc;
    while (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
      if (m_cell[r][c] != p) break;
      n++;
      r = r + dr;
      c = c + dc;
    end
    return n;
  endfunction

  function automatic bit m_line(int r, int c, int p);
    return (1 + m_run(r, c, 0, 1, p) + m_run(r, c, 0, -1, p) >= WIN_LEN)
        || (1 + m_run(r, c, 1, 0, p) + m_run(r, c, -1, 0, p) >= WIN_LEN)
        || (1 + m_run(r, c, 1, 1, p) + m_run(r, c, -1, -1, p) >= WIN_LEN)
        || (1 + m_run(r, c, -1, 1, p) + m_run(r, c, 1, -1, p) >= WIN_LEN);
  endfunction

  function automatic logic [N-1:0] m_bits(int p);
    logic [N-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_cell[r][c] == p)
          v = v | (N'(1) << (r * COLS + c));
    return v;
  endfunction

  function automatic int pick_safe();
    int q[$];
    int any_q[$];
    int p;
    p = m_turn + 1;
    for (int c = 0; c < COLS; c++) begin
      if (m_h[c] < ROWS) begin
        any_q.push_back(c);
        m_cell[m_h[c]][c] = p;
        if (!m_line(m_h[c], c, p))
          q.push_back(c);
        m_cell[m_h[c]][c] = 0;
      end
    end
    if (q.size() > 0)
      return q[$urandom_range(0, q.size() - 1)];
    return any_q[$urandom_range(0, any_q.size() - 1)];
  endfunction

  task automatic play(input int c);
    int w;
    bit rej;
    int r;
    int p;
    bit won;
    w = 0;
    while (drop_ready !== 1'b1 && w < 16) begin
      tick();
      w++;
    end
    chk("drop_ready", 64'(drop_ready), 64'd1);
    drop_valid = 1'b1;
    drop_col = 3'(c);
    tick();
    drop_valid = 1'b0;
    rej = (c >= COLS) ? 1'b1 : (m_h[c] == ROWS);
    chk("move_reject", 64'(move_reject), 64'(rej));
    if (rej) begin
      tick();
      chk("rej_p1", 64'(board_p1), 64'(m_bits(1)));
      chk("rej_p2", 64'(board_p2), 64'(m_bits(2)));
      chk("rej_turn", 64'(player_turn), 64'(m_turn));
      chk("rej_ready", 64'(drop_ready), 64'd1);
      return;
    end
    r = m_h[c];
    p = m_turn + 1;
    m_cell[r][c] = p;
    m_h[c]++;
    m_cnt++;
    won = m_line(r, c, p);
    for (int i = 0; i < 5; i++) begin
      chk("early_sv", 64'(status_valid), 64'd0);
      tick();
    end
    if (won) begin
      m_status = (p == 1) ? 2'b01 : 2'b10;
      m_over = 1'b1;
    end else if (m_cnt == N) begin
      m_status = 2'b11;
      m_over = 1'b1;
    end else begin
      m_status = 2'b00;
      m_turn = m_turn ^ 1;
    end
    chk("status_valid", 64'(status_valid), 64'd1);
    chk("game_status", 64'(game_status), 64'(m_status));
    chk("player_turn", 64'(player_turn), 64'(m_turn));
    chk("board_p1", 64'(board_p1), 64'(m_bits(1)));
    chk("board_p2", 64'(board_p2), 64'(m_bits(2)));
    tick();
    chk("sv_pulse", 64'(status_valid), 64'd0);
    chk("ready_next", 64'(drop_ready), 64'(!m_over));
  endtask

  task automatic ng();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    m_reset();
  endtask

  initial begin
    int diag_seq[10];
    bit sv_seen;
    bit tie_seen;
    m_reset();

    #3;
    chk("rst_ready", 64'(drop_ready), 64'd1);
    chk("rst_status", 64'(game_status), 64'd0);
    chk("rst_turn", 64'(player_turn), 64'd0);
    chk("rst_sv", 64'(status_valid), 64'd0);
    chk("rst_rej", 64'(move_reject), 64'd0);
    chk("rst_p1", 64'(board_p1), 64'd0);
    chk("rst_p2", 64'(board_p2), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++)
      play(3);
    chk("col3_turn", 64'(player_turn), 64'd0);

    ng();
    play(0); play(6); play(1); play(6);
    play(2); play(6); play(3);
    chk("row_win", 64'(game_status), 64'd1);
    drop_valid = 1'b1;
    drop_col = 3'd4;
    repeat (3) tick();
    drop_valid = 1'b0;
    chk("over_ready", 64'(drop_ready), 64'd0);
    chk("over_p1", 64'(board_p1), 64'(m_bits(1)));
    chk("over_sv", 64'(status_valid), 64'd0);
    chk("over_hold", 64'(game_status), 64'd1);

    ng();
    diag_seq = '{1, 0, 2, 1, 2, 2, 3, 3, 3, 3};
    foreach (diag_seq[i])
      play(diag_seq[i]);
    chk("diag_win", 64'(game_status), 64'd2);
    chk("diag_turn", 64'(player_turn), 64'd1);

    ng();
    play(2);
    play(4);
    drop_valid = 1'b1;
    drop_col = 3'd5;
    tick();
    drop_valid = 1'b0;
    tick();
    tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    m_reset();
    chk("ng_p1", 64'(board_p1), 64'd0);
    chk("ng_p2", 64'(board_p2), 64'd0);
    chk("ng_status", 64'(game_status), 64'd0);
    chk("ng_turn", 64'(player_turn), 64'd0);
    chk("ng_ready", 64'(drop_ready), 64'd1);
    sv_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (status_valid === 1'b1)
        sv_seen = 1'b1;
      tick();
    end
    chk("ng_no_sv", 64'(sv_seen), 64'd0);

    play(1);
    drop_valid = 1'b1;
    drop_col = 3'd0;
    tick();
    drop_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_p1", 64'(board_p1), 64'd0);
    chk("arst_p2", 64'(board_p2), 64'd0);
    chk("arst_ready", 64'(drop_ready), 64'd1);
    chk("arst_turn", 64'(player_turn), 64'd0);
    chk("arst_status", 64'(game_status), 64'd0);
    chk("arst_rej", 64'(move_reject), 64'd0);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    for (int g = 0; g < 6; g++) begin
      ng();
      for (int mv = 0; mv < 80 && !m_over; mv++)
        play(int'($urandom_range(0, 7)));
    end

    tie_seen = 1'b0;
    for (int g = 0; g < 40 && !tie_seen; g++) begin
      ng();
      while (!m_over)
        play(pick_safe());
      if (m_status == 2'b11)
        tie_seen = 1'b1;
    end
    chk("tie_seen", 64'(tie_seen), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
